// File: rtl/vga_vram_scaled.sv
// vga_vram_scaled: VGA timing generator that displays a byte-per-cell VRAM
// (RGB332) magnified by 2^SCALE_SHIFT in both directions, with toroidal
// scrolling through frame-latched offsets and a byte-addressed write port.
//
// Pipeline: counters (t) -> VRAM address (t+1) -> VRAM data (t+2) -> pins (t+3).
// Syncs and display-enable travel through matching delay stages.
//
// Optional feature: define VGA_VRAM_READBACK_EN to add a registered bus read
// port (data_oe). Without it data_dout is tied to 0 and data_oe is ignored.

module vga_vram_scaled #(
    parameter int C_VGA_MAX_H        = 800,
    parameter int C_VGA_MAX_V        = 525,
    parameter int C_VGA_WIDTH        = 640,
    parameter int C_VGA_HEIGHT       = 480,
    parameter int C_VGA_SYNC_H_START = 656,
    parameter int C_VGA_SYNC_H_END   = 752,
    parameter int C_VGA_SYNC_V_START = 490,
    parameter int C_VGA_SYNC_V_END   = 492,
    parameter int SCALE_SHIFT        = 4,
    parameter int COLS_BITS          = 6,
    parameter int ROWS_BITS          = 6,
    parameter int OUT_BITS           = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic [31:0]         data_length,
    input  logic [31:0]         data_address,
    input  logic [7:0]          data_din,
    output logic [7:0]          data_dout,
    input  logic                data_we,
    input  logic                data_oe,
    input  logic [31:0]         offset_h,
    input  logic [31:0]         offset_v,
    output logic                vsync,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_de,
    output logic [OUT_BITS-1:0] vga_r,
    output logic [OUT_BITS-1:0] vga_g,
    output logic [OUT_BITS-1:0] vga_b
);

    localparam int H_BITS = $clog2(C_VGA_MAX_H);
    localparam int V_BITS = $clog2(C_VGA_MAX_V);
    localparam int XW     = COLS_BITS + SCALE_SHIFT;   // wrapped X coordinate width
    localparam int YW     = ROWS_BITS + SCALE_SHIFT;   // wrapped Y coordinate width
    localparam int AW     = COLS_BITS + ROWS_BITS;     // VRAM address width
    localparam int DEPTH  = 1 << AW;

    // Active-high timing flags; pins invert the sync flags so that all
    // pipeline stages reset to zero while the pins idle high.
    typedef struct packed {
        logic hs_act;
        logic vs_act;
        logic de;
    } sync_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [H_BITS-1:0]   count_h_q, count_h_d;
    logic [V_BITS-1:0]   count_v_q, count_v_d;
    logic                line_end;
    logic                frame_end;

    logic [31:0]         off_h_q, off_h_d;
    logic [31:0]         off_v_q, off_v_d;

    logic [31:0]         x_sum;
    logic [31:0]         y_sum;
    logic [XW-1:0]       x_coord;
    logic [YW-1:0]       y_coord;

    logic [AW-1:0]       addr_q, addr_d;
    sync_t               s0_sync;
    sync_t               s1_sync_q, s1_sync_d;
    sync_t               s2_sync_q, s2_sync_d;
    logic [7:0]          vid_data_q, vid_data_d;

    logic                vga_hs_q, vga_hs_d;
    logic                vga_vs_q, vga_vs_d;
    logic                vga_de_q, vga_de_d;
    logic [OUT_BITS-1:0] vga_r_q, vga_r_d;
    logic [OUT_BITS-1:0] vga_g_q, vga_g_d;
    logic [OUT_BITS-1:0] vga_b_q, vga_b_d;
    logic                vsync_q, vsync_d;

    logic [7:0]          vram [DEPTH];
    logic [AW-1:0]       bus_idx;
    logic                bus_in_range;
    logic                wr_en;

    // ------------------------------------------------------------------
    // Colour expansion: repeat the source bits MSB-first to fill OUT_BITS
    // ------------------------------------------------------------------
    function automatic logic [OUT_BITS-1:0] expand3(input logic [2:0] v);
        logic [OUT_BITS-1:0] res;
        for (int i = 0; i < OUT_BITS; i++) begin
            res[i] = v[2 - ((OUT_BITS - 1 - i) % 3)];
        end
        return res;
    endfunction

    function automatic logic [OUT_BITS-1:0] expand2(input logic [1:0] v);
        logic [OUT_BITS-1:0] res;
        for (int i = 0; i < OUT_BITS; i++) begin
            res[i] = v[1 - ((OUT_BITS - 1 - i) % 2)];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Stage 0: raster counters and frame-boundary offset latch
    // ------------------------------------------------------------------

    // Next counter values and offset sampling on the final clock of a frame.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        count_h_d = count_h_q + H_BITS'(1);
        count_v_d = count_v_q;
        off_h_d   = off_h_q;
        off_v_d   = off_v_q;

        line_end  = (count_h_q == H_BITS'(C_VGA_MAX_H - 1));
        frame_end = line_end && (count_v_q == V_BITS'(C_VGA_MAX_V - 1));

        if (line_end) begin
            count_h_d = '0;
            if (count_v_q == V_BITS'(C_VGA_MAX_V - 1)) begin
                count_v_d = '0;
            end else begin
                count_v_d = count_v_q + V_BITS'(1);
            end
        end

        // Offsets change only between frames so a frame is never torn.
        if (frame_end) begin
            off_h_d = offset_h;
            off_v_d = offset_v;
        end
    end

    // Counter and offset registers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            count_h_q <= '0;
            count_v_q <= '0;
            off_h_q   <= '0;
            off_v_q   <= '0;
        end else begin
            count_h_q <= count_h_d;
            count_v_q <= count_v_d;
            off_h_q   <= off_h_d;
            off_v_q   <= off_v_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: scrolled coordinate -> VRAM cell address, raw timing flags
    // ------------------------------------------------------------------

    // Wrapped pixel coordinates, cell address and sync/enable decode.
    always_comb begin
        x_sum   = 32'(count_h_q) + off_h_q;
        y_sum   = 32'(count_v_q) + off_v_q;
        // Truncation to XW/YW bits gives the toroidal wrap for free.
        x_coord = x_sum[XW-1:0];
        y_coord = y_sum[YW-1:0];
        addr_d  = {y_coord[YW-1:SCALE_SHIFT], x_coord[XW-1:SCALE_SHIFT]};

        s0_sync.hs_act = (count_h_q >= H_BITS'(C_VGA_SYNC_H_START)) &&
                         (count_h_q <  H_BITS'(C_VGA_SYNC_H_END));
        s0_sync.vs_act = (count_v_q >= V_BITS'(C_VGA_SYNC_V_START)) &&
                         (count_v_q <  V_BITS'(C_VGA_SYNC_V_END));
        s0_sync.de     = (count_h_q <  H_BITS'(C_VGA_WIDTH)) &&
                         (count_v_q <  V_BITS'(C_VGA_HEIGHT));

        s1_sync_d = s0_sync;
    end

    // ------------------------------------------------------------------
    // Stage 2: VRAM read for video, timing flags delayed alongside
    // ------------------------------------------------------------------

    // Video read of the registered address; an edge that also writes the
    // same cell still returns the pre-write byte.
    always_comb begin
        vid_data_d = vram[addr_q];
        s2_sync_d  = s1_sync_q;
    end

    // Address, read-data and timing delay registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            s1_sync_q  <= '0;
            s2_sync_q  <= '0;
            vid_data_q <= '0;
        end else begin
            addr_q     <= addr_d;
            s1_sync_q  <= s1_sync_d;
            s2_sync_q  <= s2_sync_d;
            vid_data_q <= vid_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: registered pins
    // ------------------------------------------------------------------

    // Pin values: inverted syncs, blanked colour, vsync on the vs falling edge.
    always_comb begin
        vga_hs_d = ~s2_sync_q.hs_act;
        vga_vs_d = ~s2_sync_q.vs_act;
        vga_de_d = s2_sync_q.de;
        vga_r_d  = '0;
        vga_g_d  = '0;
        vga_b_d  = '0;
        if (s2_sync_q.de) begin
            vga_r_d = expand3(vid_data_q[7:5]);
            vga_g_d = expand3(vid_data_q[4:2]);
            vga_b_d = expand2(vid_data_q[1:0]);
        end
        // High on exactly the clock where the vs pin drops from 1 to 0.
        vsync_d = vga_vs_q & s2_sync_q.vs_act;
    end

    // Output pin registers; syncs idle high in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_hs_q <= 1'b1;
            vga_vs_q <= 1'b1;
            vga_de_q <= 1'b0;
            vga_r_q  <= '0;
            vga_g_q  <= '0;
            vga_b_q  <= '0;
            vsync_q  <= 1'b0;
        end else begin
            vga_hs_q <= vga_hs_d;
            vga_vs_q <= vga_vs_d;
            vga_de_q <= vga_de_d;
            vga_r_q  <= vga_r_d;
            vga_g_q  <= vga_g_d;
            vga_b_q  <= vga_b_d;
            vsync_q  <= vsync_d;
        end
    end

    assign vga_hs = vga_hs_q;
    assign vga_vs = vga_vs_q;
    assign vga_de = vga_de_q;
    assign vga_r  = vga_r_q;
    assign vga_g  = vga_g_q;
    assign vga_b  = vga_b_q;
    assign vsync  = vsync_q;

    // ------------------------------------------------------------------
    // Bus side: VRAM writes and optional readback
    // ------------------------------------------------------------------
    assign data_length  = 32'(DEPTH);
    assign bus_in_range = (data_address < 32'(DEPTH));
    assign bus_idx      = data_address[AW-1:0];
    assign wr_en        = data_we && bus_in_range;

    // VRAM write port; out-of-range addresses are dropped.
    // NOTE: the VRAM array has no reset so it maps onto block RAM and keeps
    // its picture across a reset; only the control and pipeline flops reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            vram[bus_idx] <= data_din;
        end
    end

`ifdef VGA_VRAM_READBACK_EN
    logic [7:0] rd_data_q, rd_data_d;
    logic       unused_ok;

    // Capture a read on data_oe, hold it otherwise; out-of-range reads give 0.
    always_comb begin
        rd_data_d = rd_data_q;
        if (data_oe) begin
            rd_data_d = bus_in_range ? vram[bus_idx] : 8'h00;
        end
    end

    // Readback data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign data_dout = rd_data_q;
    // High coordinate/sum bits are discarded by the wrap.
    assign unused_ok = ^{x_sum[31:XW], y_sum[31:YW],
                         x_coord[SCALE_SHIFT-1:0], y_coord[SCALE_SHIFT-1:0]};
`else
    logic unused_ok;

    assign data_dout = 8'h00;
    // data_oe has no function without readback; high coordinate/sum bits are
    // discarded by the wrap.
    assign unused_ok = ^{data_oe, x_sum[31:XW], y_sum[31:YW],
                         x_coord[SCALE_SHIFT-1:0], y_coord[SCALE_SHIFT-1:0]};
`endif

endmodule

// File: tb/tb_vga_vram_scaled.sv
// tb_vga_vram_scaled: directed bench for vga_vram_scaled on a shrunken raster
// (48x40 total, 32x24 visible) so several whole frames fit in a short run.
// VRAM geometry and scaling keep their default values.

module tb_vga_vram_scaled;

    localparam int MAX_H  = 48;
    localparam int MAX_V  = 40;
    localparam int WIDTH  = 32;
    localparam int HEIGHT = 24;
    localparam int HS0    = 36;
    localparam int HS1    = 44;
    localparam int VS0    = 30;
    localparam int VS1    = 32;
    localparam int LIMIT  = 4000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_length;
    logic [31:0] data_address = '0;
    logic [7:0]  data_din = '0;
    logic [7:0]  data_dout;
    logic        data_we = 1'b0;
    logic        data_oe = 1'b0;
    logic [31:0] offset_h = '0;
    logic [31:0] offset_v = '0;
    logic        vsync;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic [11:0] rgb;

    int n_cmp = 0;
    int n_bad = 0;

    assign rgb = {vga_r, vga_g, vga_b};

    always #5 clk = ~clk;

    vga_vram_scaled #(
        .C_VGA_MAX_H       (MAX_H),
        .C_VGA_MAX_V       (MAX_V),
        .C_VGA_WIDTH       (WIDTH),
        .C_VGA_HEIGHT      (HEIGHT),
        .C_VGA_SYNC_H_START(HS0),
        .C_VGA_SYNC_H_END  (HS1),
        .C_VGA_SYNC_V_START(VS0),
        .C_VGA_SYNC_V_END  (VS1),
        .SCALE_SHIFT       (4),
        .COLS_BITS         (6),
        .ROWS_BITS         (6),
        .OUT_BITS          (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data_length (data_length),
        .data_address(data_address),
        .data_din    (data_din),
        .data_dout   (data_dout),
        .data_we     (data_we),
        .data_oe     (data_oe),
        .offset_h    (offset_h),
        .offset_v    (offset_v),
        .vsync       (vsync),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [7:0] din);
        data_address = addr;
        data_din     = din;
        data_we      = 1'b1;
        step();
        data_we      = 1'b0;
    endtask

    task automatic wait_vsync(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < LIMIT && !found; i++) begin
            step();
            if (vsync === 1'b1) found = 1'b1;
        end
        if (!found) check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_de_rise(input string tag);
        bit   found = 1'b0;
        logic prev  = vga_de;
        for (int i = 0; i < LIMIT && !found; i++) begin
            step();
            if (vga_de === 1'b1 && prev === 1'b0) found = 1'b1;
            prev = vga_de;
        end
        if (!found) check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int   n;
        int   hs_low;
        int   hs_fall;
        int   vs_low;
        int   de_cnt;
        logic prev_hs;
        logic [11:0] exp_rgb;

        // Reset values
        repeat (3) step();
        check("rst_hs", 32'(vga_hs), 32'd1);
        check("rst_vs", 32'(vga_vs), 32'd1);
        check("rst_de", 32'(vga_de), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_vsync", 32'(vsync), 32'd0);
        check("rst_dout", 32'(data_dout), 32'd0);
        check("data_length", data_length, 32'd4096);

        // Release and load VRAM: (0,0)=FF, (0,1)=24, (0,63)=A5, (1,0)=92
        reset_n = 1'b1;
        bus_write(32'd0, 8'hFF);
        bus_write(32'd1, 8'h24);
        bus_write(32'd63, 8'hA5);
        bus_write(32'd64, 8'h92);
        bus_write(32'd7, 8'hA5);
        bus_write(32'd4096, 8'h11);   // out of range, must not alias cell 0

`ifdef VGA_VRAM_READBACK_EN
        data_address = 32'd7;
        data_oe      = 1'b1;
        step();
        data_oe      = 1'b0;
        check("rb_read7", 32'(data_dout), 32'h A5);
        step();
        check("rb_hold", 32'(data_dout), 32'h A5);
        data_we      = 1'b1;
        data_din     = 8'h5A;
        data_oe      = 1'b1;
        step();
        data_we      = 1'b0;
        check("rb_old_on_write", 32'(data_dout), 32'h A5);
        step();
        check("rb_new_data", 32'(data_dout), 32'h 5A);
        data_address = 32'd4096;
        step();
        check("rb_out_of_range", 32'(data_dout), 32'd0);
        data_address = 32'd0;
        step();
        check("rb_addr0", 32'(data_dout), 32'h FF);
        data_oe      = 1'b0;
`else
        data_address = 32'd7;
        data_oe      = 1'b1;
        step();
        data_oe      = 1'b0;
        check("dout_tied_zero", 32'(data_dout), 32'd0);
`endif

        // One whole frame, vsync pulse to vsync pulse
        wait_vsync("vsync_wait_1");
        n = 0; hs_low = 0; hs_fall = 0; vs_low = 0; de_cnt = 0;
        prev_hs = vga_hs;
        do begin
            if (!vga_hs) hs_low++;
            if (prev_hs && !vga_hs) hs_fall++;
            prev_hs = vga_hs;
            if (!vga_vs) vs_low++;
            if (vga_de) de_cnt++;
            step();
            n++;
        end while (vsync !== 1'b1 && n < LIMIT);
        check("frame_len", 32'(n), 32'(MAX_H * MAX_V));
        check("hs_low_clocks", 32'(hs_low), 32'((HS1 - HS0) * MAX_V));
        check("hs_pulses", 32'(hs_fall), 32'(MAX_V));
        check("vs_low_clocks", 32'(vs_low), 32'((VS1 - VS0) * MAX_H));
        check("de_clocks", 32'(de_cnt), 32'(WIDTH * HEIGHT));

        // Offset 0 frame; offset_h=8 arrives mid-frame and must not apply yet
        wait_de_rise("de_wait_a");
        offset_h = 32'd8;
        for (int k = 0; k < WIDTH; k++) begin
            exp_rgb = (k < 16) ? 12'hFFF : 12'h220;
            check($sformatf("off0_px%0d", k), 32'(rgb), 32'(exp_rgb));
            step();
        end
        check("blank_de", 32'(vga_de), 32'd0);
        check("blank_rgb", 32'(rgb), 32'd0);
        repeat (16 * MAX_H - WIDTH) step();
        check("row1_de", 32'(vga_de), 32'd1);
        check("row1_px0", 32'(rgb), 32'h99A);

        // Offset 8 frame: cell 0 for 8 clocks, then cell 1
        wait_vsync("vsync_wait_2");
        wait_de_rise("de_wait_b");
        for (int k = 0; k < 24; k++) begin
            exp_rgb = (k < 8) ? 12'hFFF : 12'h220;
            check($sformatf("off8_px%0d", k), 32'(rgb), 32'(exp_rgb));
            step();
        end
        offset_h = 32'd1020;

        // Offset 1020 frame: wraps to cell 63 for 4 clocks, then cells 0 and 1
        wait_vsync("vsync_wait_3");
        wait_de_rise("de_wait_c");
        for (int k = 0; k < WIDTH; k++) begin
            exp_rgb = (k < 4) ? 12'hB25 : (k < 20) ? 12'hFFF : 12'h220;
            check($sformatf("off1020_px%0d", k), 32'(rgb), 32'(exp_rgb));
            step();
        end

        // Asynchronous reset in the middle of visible line 10
        repeat (10 * MAX_H - WIDTH) step();
        check("pre_reset_de", 32'(vga_de), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_hs", 32'(vga_hs), 32'd1);
        check("async_rst_vs", 32'(vga_vs), 32'd1);
        check("async_rst_de", 32'(vga_de), 32'd0);
        check("async_rst_rgb", 32'(rgb), 32'd0);
        check("async_rst_vsync", 32'(vsync), 32'd0);
        repeat (2) step();
        reset_n = 1'b1;

        // Restart: pixel (0,0) three clocks after release with offsets cleared
        step();
        step();
        check("restart_de_lat2", 32'(vga_de), 32'd0);
        step();
        check("restart_de_lat3", 32'(vga_de), 32'd1);
        check("restart_px0_vram_kept", 32'(rgb), 32'hFFF);
        n = 3;
        while (vsync !== 1'b1 && n < LIMIT) begin
            step();
            n++;
        end
        check("restart_vsync_delay", 32'(n), 32'(VS0 * MAX_H + 3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
